// File: rtl/fifo_byte_packer.sv
// Packs single-lane reads from a synchronous FIFO into multi-lane words,
// with a flush path that emits a partially filled word.
module fifo_byte_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        rd_en_o,
    input  logic [DATA_WIDTH-1:0]       rdata_i,
    input  logic                        empty_i,
    input  logic                        flush_i,
    output logic [DATA_WIDTH*LANES-1:0] m_data_o,
    output logic [LANES-1:0]            m_keep_o,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic                        flush_done_o
);

    localparam int CW = $clog2(LANES) + 1;
    localparam int WW = DATA_WIDTH * LANES;

    typedef enum logic [1:0] {
        FILL,
        DRAIN,
        FLUSH_EMIT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_inflight;
    logic             r_flush_pend;
    logic [WW-1:0]    r_out_data;
    logic [LANES-1:0] r_out_keep;
    logic             r_out_valid;

    logic [WW-1:0]    w_acc_cap;
    logic [WW-1:0]    w_part_data;
    logic [LANES-1:0] w_part_keep;
    logic [CW-1:0]    w_cnt_cap;
    logic [CW-1:0]    w_cnt_eff;
    logic             w_out_free;
    logic             w_move;
    logic             w_part_load;
    logic             w_done;
    logic             w_rd;

    // Lane write for the byte arriving this cycle, and the masked partial word.
    always_comb begin
        w_acc_cap   = r_acc;
        w_part_data = '0;
        w_part_keep = '0;
        for (int l = 0; l < LANES; l++) begin
            if (r_inflight && (r_cnt == CW'(l))) begin
                w_acc_cap[l*DATA_WIDTH +: DATA_WIDTH] = rdata_i;
            end
            if (CW'(l) < r_cnt) begin
                w_part_keep[l] = 1'b1;
                w_part_data[l*DATA_WIDTH +: DATA_WIDTH] =
                    r_acc[l*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_cnt_cap  = r_cnt + {{(CW-1){1'b0}}, r_inflight};
    assign w_out_free = !r_out_valid || m_ready_i;
    assign w_move     = (w_cnt_cap == CW'(LANES)) && w_out_free;
    // A word leaving the accumulator this edge frees all lanes for the next read.
    assign w_cnt_eff  = w_move ? '0 : w_cnt_cap;

    assign w_rd = rst && !empty_i && !r_flush_pend && !flush_i &&
                  (r_state == FILL) && (w_cnt_eff < CW'(LANES));

    always_comb begin
        w_state_nxt = r_state;
        w_part_load = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            FILL: begin
                if (flush_i) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!r_inflight) w_state_nxt = FLUSH_EMIT;
            end
            FLUSH_EMIT: begin
                if (r_cnt == '0) begin
                    w_done      = 1'b1;
                    w_state_nxt = FILL;
                end else if ((r_cnt != CW'(LANES)) && w_out_free) begin
                    w_part_load = 1'b1;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= FILL;
            r_flush_pend <= 1'b0;
            r_inflight   <= 1'b0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_out_data   <= '0;
            r_out_keep   <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_pend <= (w_state_nxt != FILL);
            r_inflight   <= w_rd;
            if (r_out_valid && m_ready_i) begin
                r_out_valid <= 1'b0;
            end
            if (w_move) begin
                r_out_data  <= w_acc_cap;
                r_out_keep  <= '1;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_cnt       <= '0;
            end else if (w_part_load) begin
                r_out_data  <= w_part_data;
                r_out_keep  <= w_part_keep;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_cnt       <= '0;
            end else begin
                r_acc <= w_acc_cap;
                r_cnt <= w_cnt_cap;
            end
        end
    end

    assign rd_en_o      = w_rd;
    assign m_data_o     = r_out_data;
    assign m_keep_o     = r_out_keep;
    assign m_valid_o    = r_out_valid;
    assign flush_done_o = w_done;

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Scoreboard bench for fifo_byte_packer with a behavioural synchronous FIFO.
module tb_fifo_byte_packer;

    logic        clk;
    logic        rst;
    logic        rd_en_o;
    logic [7:0]  rdata_i;
    logic        empty_i;
    logic        flush_i;
    logic [31:0] m_data_o;
    logic [3:0]  m_keep_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic        flush_done_o;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];

    int n_chk    = 0;
    int n_fail   = 0;
    int n_reads  = 0;
    int run      = 0;
    int max_run  = 0;
    int done_cnt = 0;
    int n_xfer   = 0;

    logic        hold_chk = 1'b0;
    logic [31:0] held_d;
    logic [3:0]  held_k;

    fifo_byte_packer #(.DATA_WIDTH(8), .LANES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en_o      (rd_en_o),
        .rdata_i      (rdata_i),
        .empty_i      (empty_i),
        .flush_i      (flush_i),
        .m_data_o     (m_data_o),
        .m_keep_o     (m_keep_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .flush_done_o (flush_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Synchronous FIFO model: data appears the cycle after an accepted read.
    always @(posedge clk) begin
        if (rd_en_o && !empty_i && fifo_q.size() > 0) begin
            rdata_i <= fifo_q.pop_front();
            n_reads++;
        end
        if (rd_en_o) begin
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        empty_i <= (fifo_q.size() == 0);
    end

    // Monitor: transfers happen at the next posedge when valid&&ready here.
    always @(negedge clk) begin
        if (flush_done_o) done_cnt++;
        if (!rst) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                chk("hold_valid", 64'(m_valid_o), 64'(1));
                chk("hold_data", 64'(m_data_o), 64'(held_d));
                chk("hold_keep", 64'(m_keep_o), 64'(held_k));
            end
            hold_chk = 1'b0;
            if (m_valid_o && m_ready_i) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(m_data_o), 64'hDEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word_data", 64'(m_data_o), 64'(e.d));
                    chk("word_keep", 64'(m_keep_o), 64'(e.k));
                end
            end else if (m_valid_o) begin
                hold_chk = 1'b1;
                held_d   = m_data_o;
                held_k   = m_keep_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_bytes(input logic [7:0] b[$]);
        foreach (b[i]) fifo_q.push_back(b[i]);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
        exp_t e;
        e.d = d;
        e.k = k;
        exp_q.push_back(e);
    endtask

    task automatic wait_sb(input string nm, input int maxc);
        int c;
        c = 0;
        while (exp_q.size() > 0 && c < maxc) begin
            tick();
            c++;
        end
        chk(nm, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int maxc);
        int c;
        c = 0;
        while (done_cnt == d0 && c < maxc) begin
            tick();
            c++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int rd0;
        int d0;
        int x0;
        int c;
        logic [7:0] bq[$];

        rst       = 1'b0;
        flush_i   = 1'b0;
        m_ready_i = 1'b1;
        rdata_i   = '0;
        empty_i   = 1'b1;
        ticks(3);

        chk("rst_valid", 64'(m_valid_o), 64'(0));
        chk("rst_data", 64'(m_data_o), 64'(0));
        chk("rst_keep", 64'(m_keep_o), 64'(0));
        chk("rst_done", 64'(flush_done_o), 64'(0));
        chk("rst_rd_en", 64'(rd_en_o), 64'(0));
        rst = 1'b1;
        ticks(2);

        // Stream
        rd0 = n_reads;
        expect_word(32'h44332211, 4'hF);
        expect_word(32'h88776655, 4'hF);
        bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        push_bytes(bq);
        wait_sb("stream_words", 40);
        chk("stream_reads", 64'(n_reads - rd0), 64'(8));
        chk("stream_rd_run", 64'(max_run), 64'(8));
        ticks(3);

        // Backpressure
        m_ready_i = 1'b0;
        rd0 = n_reads;
        expect_word(32'h04030201, 4'hF);
        expect_word(32'h08070605, 4'hF);
        expect_word(32'h0C0B0A09, 4'hF);
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
               8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        push_bytes(bq);
        ticks(20);
        chk("bp_reads_stall", 64'(n_reads - rd0), 64'(8));
        chk("bp_rd_en_low", 64'(rd_en_o), 64'(0));
        chk("bp_valid_held", 64'(m_valid_o), 64'(1));
        m_ready_i = 1'b1;
        wait_sb("bp_words", 40);
        chk("bp_reads_total", 64'(n_reads - rd0), 64'(12));
        ticks(3);

        // Partial flush
        bq = '{8'hA1, 8'hB2, 8'hC3};
        push_bytes(bq);
        ticks(8);
        expect_word(32'h00C3B2A1, 4'h7);
        d0 = done_cnt;
        pulse_flush();
        wait_sb("partial_word", 20);
        wait_done(d0, 20);
        ticks(5);
        chk("partial_done_pulse", 64'(done_cnt - d0), 64'(1));

        // Empty flush
        x0 = n_xfer;
        d0 = done_cnt;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        chk("empty_done_hi", 64'(flush_done_o), 64'(1));
        tick();
        chk("empty_done_lo", 64'(flush_done_o), 64'(0));
        ticks(3);
        chk("empty_no_word", 64'(n_xfer - x0), 64'(0));
        chk("empty_done_cnt", 64'(done_cnt - d0), 64'(1));

        // Race: flush on the edge that captures the second byte
        rd0 = n_reads;
        expect_word(32'h00000201, 4'h3);
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        push_bytes(bq);
        c = 0;
        while (n_reads - rd0 < 2 && c < 20) begin
            tick();
            c++;
        end
        chk("race_setup_reads", 64'(n_reads - rd0), 64'(2));
        d0 = done_cnt;
        pulse_flush();
        wait_done(d0, 20);
        chk("race_done_seen", 64'(done_cnt - d0), 64'(1));
        chk("race_no_read", 64'(n_reads - rd0), 64'(2));
        wait_sb("race_word", 10);
        ticks(8);
        expect_word(32'h00050403, 4'h7);
        pulse_flush();
        wait_sb("race_tail", 20);
        ticks(4);

        // Reset mid-operation: one word held, two bytes accumulated
        m_ready_i = 1'b0;
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        push_bytes(bq);
        ticks(15);
        chk("mid_valid_pre", 64'(m_valid_o), 64'(1));
        rst = 1'b0;
        tick();
        chk("mid_rst_valid", 64'(m_valid_o), 64'(0));
        chk("mid_rst_data", 64'(m_data_o), 64'(0));
        chk("mid_rst_keep", 64'(m_keep_o), 64'(0));
        chk("mid_rst_done", 64'(flush_done_o), 64'(0));
        rst = 1'b1;
        m_ready_i = 1'b1;
        tick();
        expect_word(32'hD4D3D2D1, 4'hF);
        bq = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        push_bytes(bq);
        wait_sb("post_rst_word", 30);
        ticks(5);
        chk("final_sb_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
